// File: rtl/plab3_mem_domain_line_responder_pkg.sv
// Shared message layout and type encodings for the domain-tagged line responder.
// Request: {type, opaque, addr, len, data}; response: {type, opaque, len, data}.
package plab3_mem_domain_line_responder_pkg;

    localparam int unsigned abw        = 32;
    localparam int unsigned clw        = 128;
    localparam int unsigned type_nbits = 3;
    localparam int unsigned len_nbits  = 4;

    localparam logic [2:0] mem_type_read       = 3'd0;
    localparam logic [2:0] mem_type_write      = 3'd1;
    localparam logic [2:0] mem_type_write_init = 3'd2;

    function automatic int unsigned mem_req_nbits(input int unsigned o);
        return type_nbits + o + abw + len_nbits + clw;
    endfunction

    function automatic int unsigned mem_resp_nbits(input int unsigned o);
        return type_nbits + o + len_nbits + clw;
    endfunction

endpackage

// File: rtl/plab3_mem_DomainLineStore.sv
// Line store with per-line valid/owner tags; synchronous write, registered read.
// Reads from a non-owning domain or of a never-written line return zero.
module plab3_mem_DomainLineStore
    import plab3_mem_domain_line_responder_pkg::*;
#(
    parameter int unsigned nlines = 256,
    parameter int unsigned idw    = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic           wen,
    input  logic           ren,
    input  logic [idw-1:0] idx,
    input  logic [clw-1:0] wdata,
    input  logic           domain,
    output logic [clw-1:0] rdata
);

    logic [clw-1:0]    mem [nlines];
    logic [nlines-1:0] valid_q;
    logic [nlines-1:0] owner_q;
    logic [clw-1:0]    rdata_q;

    // Data array has no reset; the valid tags alone guard against stale contents.
    always_ff @(posedge clk) begin
        if (en && wen && !reset) begin
            mem[idx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            owner_q <= '0;
            rdata_q <= '0;
        end else if (en) begin
            if (wen) begin
                valid_q[idx] <= 1'b1;
                owner_q[idx] <= domain;
                rdata_q      <= '0;
            end else if (ren && valid_q[idx] && (owner_q[idx] == domain)) begin
                rdata_q <= mem[idx];
            end else begin
                rdata_q <= '0;
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/plab3_mem_domain_line_responder.sv
// Memory-side endpoint for memreq/memresp: one request in flight, fixed latency,
// domain-isolated line reads.
module plab3_mem_domain_line_responder
    import plab3_mem_domain_line_responder_pkg::*;
#(
    parameter int unsigned p_mem_nbytes   = 4096,
    parameter int unsigned p_latency      = 2,
    parameter int unsigned p_opaque_nbits = 8
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      domain,
    input  logic [mem_req_nbits(p_opaque_nbits)-1:0]  memreq_msg,
    input  logic                                      memreq_val,
    output logic                                      memreq_rdy,
    output logic [mem_resp_nbits(p_opaque_nbits)-1:0] memresp_msg,
    output logic                                      memresp_val,
    input  logic                                      memresp_rdy,
    output logic                                      memresp_domain
);

    localparam int unsigned o         = p_opaque_nbits;
    localparam int unsigned req_nbits = mem_req_nbits(p_opaque_nbits);
    localparam int unsigned nlines    = p_mem_nbytes * 8 / clw;
    localparam int unsigned idw       = $clog2(nlines);
    localparam logic [3:0]  lat_m1    = 4'(p_latency - 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic accept;

    logic [2:0]     req_type;
    logic [o-1:0]   req_opaque;
    logic [abw-1:0] req_addr;
    logic [clw-1:0] req_data;

    assign req_type   = memreq_msg[req_nbits-1 -: type_nbits];
    assign req_opaque = memreq_msg[clw + len_nbits + abw +: o];
    assign req_addr   = memreq_msg[clw + len_nbits +: abw];
    assign req_data   = memreq_msg[clw-1:0];

    // Offset, length and high address bits are don't-cares; high bits alias.
    logic unused_req_bits;
    assign unused_req_bits = ^{memreq_msg[clw +: len_nbits], req_addr[3:0],
                               req_addr[abw-1:4+idw]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        memreq_rdy  = 1'b0;
        memresp_val = 1'b0;
        accept      = 1'b0;
        unique case (state_q)
            StIdle: begin
                memreq_rdy = 1'b1;
                if (memreq_val) begin
                    accept  = 1'b1;
                    cnt_d   = lat_m1;
                    state_d = (p_latency == 1) ? StResp : StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                memresp_val = 1'b1;
                if (memresp_rdy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    logic [2:0]   type_q;
    logic [o-1:0] opaque_q;
    logic         domain_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            type_q   <= '0;
            opaque_q <= '0;
            domain_q <= 1'b0;
        end else if (accept) begin
            type_q   <= req_type;
            opaque_q <= req_opaque;
            domain_q <= domain;
        end
    end

    logic           st_wen;
    logic           st_ren;
    logic [clw-1:0] st_rdata;

    assign st_wen = (req_type == mem_type_write) || (req_type == mem_type_write_init);
    assign st_ren = (req_type == mem_type_read);

    plab3_mem_DomainLineStore #(
        .nlines (nlines),
        .idw    (idw)
    ) u_store (
        .clk    (clk),
        .reset  (reset),
        .en     (accept),
        .wen    (st_wen),
        .ren    (st_ren),
        .idx    (req_addr[4 +: idw]),
        .wdata  (req_data),
        .domain (domain),
        .rdata  (st_rdata)
    );

    assign memresp_msg    = {type_q, opaque_q, {len_nbits{1'b0}}, st_rdata};
    assign memresp_domain = domain_q;

endmodule

// File: tb/tb_plab3_mem_domain_line_responder.sv
// Directed bench with a response scoreboard; dut0 uses latency 2, dut1 latency 1.
module tb_plab3_mem_domain_line_responder;

    localparam int req_nbits  = 3 + 8 + 32 + 4 + 128;
    localparam int resp_nbits = 3 + 8 + 4 + 128;

    localparam logic [127:0] line0 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] linea = {16{8'hAA}};
    localparam logic [127:0] line5 = {16{8'h55}};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic domain = 1'b0;
    logic [req_nbits-1:0] memreq_msg = '0;
    logic memreq_val0 = 1'b0;
    logic memreq_val1 = 1'b0;
    logic memresp_rdy = 1'b0;

    logic memreq_rdy0, memreq_rdy1, memresp_val0, memresp_val1;
    logic memresp_domain0, memresp_domain1;
    logic [resp_nbits-1:0] memresp_msg0, memresp_msg1;

    int sel = 0;
    int checks = 0;
    int errors = 0;

    logic [resp_nbits-1:0] exp_msg_q[$];
    logic                  exp_dom_q[$];

    logic req_rdy, resp_val, resp_dom;
    logic [resp_nbits-1:0] resp_msg;
    assign req_rdy  = (sel == 0) ? memreq_rdy0 : memreq_rdy1;
    assign resp_val = (sel == 0) ? memresp_val0 : memresp_val1;
    assign resp_dom = (sel == 0) ? memresp_domain0 : memresp_domain1;
    assign resp_msg = (sel == 0) ? memresp_msg0 : memresp_msg1;

    always #5 clk = ~clk;

    plab3_mem_domain_line_responder #(
        .p_mem_nbytes   (4096),
        .p_latency      (2),
        .p_opaque_nbits (8)
    ) dut0 (
        .clk            (clk),
        .reset          (reset),
        .domain         (domain),
        .memreq_msg     (memreq_msg),
        .memreq_val     (memreq_val0),
        .memreq_rdy     (memreq_rdy0),
        .memresp_msg    (memresp_msg0),
        .memresp_val    (memresp_val0),
        .memresp_rdy    (memresp_rdy),
        .memresp_domain (memresp_domain0)
    );

    plab3_mem_domain_line_responder #(
        .p_mem_nbytes   (4096),
        .p_latency      (1),
        .p_opaque_nbits (8)
    ) dut1 (
        .clk            (clk),
        .reset          (reset),
        .domain         (domain),
        .memreq_msg     (memreq_msg),
        .memreq_val     (memreq_val1),
        .memreq_rdy     (memreq_rdy1),
        .memresp_msg    (memresp_msg1),
        .memresp_val    (memresp_val1),
        .memresp_rdy    (memresp_rdy),
        .memresp_domain (memresp_domain1)
    );

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the mandatory idle cycle.
    task automatic xact(input int s, input logic [2:0] t, input logic [7:0] op,
                        input logic [31:0] addr, input logic [127:0] wdata, input logic dom,
                        input logic [127:0] exp_data, input int lat, input int stall,
                        input string tag);
        int n;
        int w;
        logic [resp_nbits-1:0] e_msg;
        logic e_dom;
        sel = s;
        memreq_msg = {t, op, addr, 4'hF, wdata};
        domain = dom;
        if (s == 0) memreq_val0 = 1'b1; else memreq_val1 = 1'b1;
        #1;
        w = 0;
        while (!req_rdy && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        chk({tag, " req_rdy"}, 160'(req_rdy), 160'(1));
        @(posedge clk);
        exp_msg_q.push_back({t, op, 4'h0, exp_data});
        exp_dom_q.push_back(dom);
        #1;
        memreq_val0 = 1'b0;
        memreq_val1 = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_val && n < 20);
        chk({tag, " latency"}, 160'(n), 160'(lat));
        e_msg = exp_msg_q.pop_front();
        e_dom = exp_dom_q.pop_front();
        chk({tag, " msg"}, 160'(resp_msg), 160'(e_msg));
        chk({tag, " domain"}, 160'(resp_dom), 160'(e_dom));
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk({tag, " stall"}, 160'({resp_val, req_rdy, resp_dom, resp_msg}),
                160'({1'b1, 1'b0, e_dom, e_msg}));
        end
        memresp_rdy = 1'b1;
        @(posedge clk);
        #1;
        memresp_rdy = 1'b0;
        @(negedge clk);
        chk({tag, " idle"}, 160'({req_rdy, resp_val}), 160'(2'b10));
    endtask

    // Write accepted by dut0, then reset asserted while it is waiting.
    task automatic write_then_reset(input logic [31:0] addr, input logic [127:0] wdata,
                                    input logic dom);
        sel = 0;
        memreq_msg = {3'd1, 8'h77, addr, 4'h0, wdata};
        domain = dom;
        memreq_val0 = 1'b1;
        #1;
        chk("wrst req_rdy", 160'(req_rdy), 160'(1));
        @(posedge clk);
        #1;
        memreq_val0 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("wrst state", 160'({resp_val, req_rdy, resp_dom, resp_msg}),
            160'({1'b0, 1'b1, 1'b0, {resp_nbits{1'b0}}}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        sel = 0;
        #1;
        chk("rst req_rdy", 160'(req_rdy), 160'(1));
        chk("rst resp_val", 160'(resp_val), 160'(0));
        chk("rst resp_msg", 160'(resp_msg), 160'(0));
        chk("rst resp_dom", 160'(resp_dom), 160'(0));
        @(negedge clk);

        xact(0, 3'd1, 8'h11, 32'h0000_0040, line0, 1'b0, '0, 2, 0, "wr d0");
        xact(0, 3'd0, 8'h12, 32'h0000_0040, line5, 1'b0, line0, 2, 0, "rd d0");
        xact(0, 3'd0, 8'h13, 32'h0000_0040, '0, 1'b1, '0, 2, 0, "rd d1 foreign");
        xact(0, 3'd2, 8'h14, 32'h0000_0040, linea, 1'b1, '0, 2, 0, "wrinit d1");
        xact(0, 3'd0, 8'h15, 32'h0000_0040, '0, 1'b0, '0, 2, 0, "rd d0 foreign");
        xact(0, 3'd0, 8'h16, 32'h0000_0040, '0, 1'b1, linea, 2, 0, "rd d1 own");
        xact(0, 3'd0, 8'h17, 32'h0000_0200, '0, 1'b0, '0, 2, 0, "rd unwritten");
        xact(0, 3'd0, 8'h18, 32'h0000_1040, '0, 1'b1, linea, 2, 0, "rd alias");
        xact(0, 3'd3, 8'h19, 32'h0000_0040, line5, 1'b1, '0, 2, 0, "other type");
        xact(0, 3'd0, 8'h1A, 32'h0000_0040, '0, 1'b1, linea, 2, 0, "rd after other");
        xact(0, 3'd0, 8'h1B, 32'h0000_004F, '0, 1'b1, linea, 2, 5, "rd stall");

        xact(1, 3'd1, 8'h21, 32'h0000_1040, line5, 1'b0, '0, 1, 0, "lat1 wr alias");
        xact(1, 3'd0, 8'h22, 32'h0000_0040, '0, 1'b0, line5, 1, 0, "lat1 rd");

        write_then_reset(32'h0000_0080, line0, 1'b0);
        xact(0, 3'd0, 8'h31, 32'h0000_0080, '0, 1'b0, '0, 2, 0, "rd after reset");
        xact(0, 3'd0, 8'h32, 32'h0000_0040, '0, 1'b1, '0, 2, 0, "rd cleared");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
